// File: rtl/key_debounce_pkg.sv
// key_pkg: shared definitions for the push-button conditioning path.
//   key_state_e  - debounce FSM states
//   KEY_IDLE     - electrical level of a released (active-low) key
//   *_DEF        - default timing for a 50 MHz clock, shared with the
//                  downstream press detector and the bench
package key_pkg;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    DB_PRESS   = 2'd1,
    PRESSED    = 2'd2,
    DB_RELEASE = 2'd3
  } key_state_e;

  localparam logic KEY_IDLE     = 1'b1;

  localparam int   DEB_CYC_DEF  = 1_000_000;   // 20 ms @ 50 MHz
  localparam int   LONG_CYC_DEF = 50_000_000;  // 1 s @ 50 MHz
  localparam int   CNT_W_DEF    = 26;

endpackage

// File: rtl/key_debounce_if.sv
// key_debounce_if: pin-side and conditioned-side signals of one key.
//   key_in   - raw button pin, asynchronous, active-low
//   key_out  - debounced level, active-low
//   key_long - one-cycle long-press pulse
//   key_busy - debounce FSM not idle
// Modports: master = environment driving the pin, slave = key_debounce.
interface key_debounce_if;

  logic key_in;
  logic key_out;
  logic key_long;
  logic key_busy;

  modport master (
    output key_in,
    input  key_out,
    input  key_long,
    input  key_busy
  );

  modport slave (
    input  key_in,
    output key_out,
    output key_long,
    output key_busy
  );

endinterface

// File: rtl/key_debounce_sync.sv
// key_sync: two-flop synchroniser for a single asynchronous pin.
//   clk    - destination clock
//   rst_n  - asynchronous active-low reset
//   din    - asynchronous input
//   dout   - synchronised output, lags din by two clk edges
// RST_VAL sets the level both flops take in reset, so the output shows the
// pin's idle level while reset is held and just after it is released.
module key_sync #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic dout
);

  logic sync_p0;
  logic sync_p1;

  // Stage p0: first capture, may go metastable.
  // Stage p1: resolved copy handed to the clk domain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_p0 <= RST_VAL;
      sync_p1 <= RST_VAL;
    end else begin
      sync_p0 <= din;
      sync_p1 <= sync_p0;
    end
  end

  assign dout = sync_p1;

endmodule

// File: rtl/key_debounce.sv
// key_debounce: synchronise and debounce an active-low mechanical key.
//   clk      - system clock
//   rst_n    - asynchronous active-low reset
//   kif      - key_debounce_if.slave: key_in in; key_out, key_long,
//              key_busy out (all outputs registered)
// key_out only changes after DEB_CYC consecutive equal synchronised samples,
// so a single physical press gives exactly one falling edge. key_long fires
// once per press when the key has been held LONG_CYC cycles.
module key_debounce
  import key_pkg::*;
#(
  parameter int DEB_CYC  = DEB_CYC_DEF,
  parameter int LONG_CYC = LONG_CYC_DEF,
  parameter int CNT_W    = CNT_W_DEF
) (
  input logic           clk,
  input logic           rst_n,
  key_debounce_if.slave kif
);

  localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEB_CYC - 1);
  localparam logic [CNT_W-1:0] LONG_MAX  = CNT_W'(LONG_CYC);
  localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  // Hold counter stops at LONG_MAX so a very long press never wraps around
  // and re-triggers the long-press pulse.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v >= LONG_MAX) ? LONG_MAX : v + CNT_ONE;
  endfunction

  logic             key_sync;
  key_state_e       state, state_nxt;
  logic [CNT_W-1:0] deb_cnt, deb_cnt_nxt;
  logic [CNT_W-1:0] hold_cnt, hold_cnt_nxt;
  logic             key_out_q, key_out_nxt;
  logic             key_long_q, key_long_nxt;
  logic             key_busy_q, key_busy_nxt;

  key_sync #(
    .RST_VAL (KEY_IDLE)
  ) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .din   (kif.key_in),
    .dout  (key_sync)
  );

  // State, counters and outputs share one register stage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      deb_cnt    <= '0;
      hold_cnt   <= '0;
      key_out_q  <= KEY_IDLE;
      key_long_q <= 1'b0;
      key_busy_q <= 1'b0;
    end else begin
      state      <= state_nxt;
      deb_cnt    <= deb_cnt_nxt;
      hold_cnt   <= hold_cnt_nxt;
      key_out_q  <= key_out_nxt;
      key_long_q <= key_long_nxt;
      key_busy_q <= key_busy_nxt;
    end
  end

  // A level reversal is tested before the threshold so that, when both
  // happen on the same sample, the debounce restarts.
  always_comb begin
    state_nxt    = state;
    deb_cnt_nxt  = deb_cnt;
    hold_cnt_nxt = hold_cnt;
    case (state)
      IDLE: begin
        if (key_sync != KEY_IDLE) begin
          state_nxt   = DB_PRESS;
          deb_cnt_nxt = CNT_ONE;
        end
      end
      DB_PRESS: begin
        if (key_sync == KEY_IDLE) begin
          state_nxt   = IDLE;
          deb_cnt_nxt = '0;
        end else if (deb_cnt == DEB_LAST) begin
          state_nxt    = PRESSED;
          deb_cnt_nxt  = '0;
          hold_cnt_nxt = '0;
        end else begin
          deb_cnt_nxt = deb_cnt + CNT_ONE;
        end
      end
      PRESSED: begin
        hold_cnt_nxt = sat_inc(hold_cnt);
        if (key_sync == KEY_IDLE) begin
          state_nxt   = DB_RELEASE;
          deb_cnt_nxt = CNT_ONE;
        end
      end
      DB_RELEASE: begin
        // Hold time keeps running while a release is being qualified.
        hold_cnt_nxt = sat_inc(hold_cnt);
        if (key_sync != KEY_IDLE) begin
          state_nxt   = PRESSED;
          deb_cnt_nxt = '0;
        end else if (deb_cnt == DEB_LAST) begin
          state_nxt   = IDLE;
          deb_cnt_nxt = '0;
        end else begin
          deb_cnt_nxt = deb_cnt + CNT_ONE;
        end
      end
      default: begin
        state_nxt    = IDLE;
        deb_cnt_nxt  = '0;
        hold_cnt_nxt = '0;
      end
    endcase
  end

  // Outputs are derived from the next state so they change on the same edge
  // as the state register.
  always_comb begin
    key_out_nxt  = KEY_IDLE;
    key_busy_nxt = 1'b0;
    key_long_nxt = 1'b0;
    if (state_nxt inside {PRESSED, DB_RELEASE}) begin
      key_out_nxt = ~KEY_IDLE;
    end
    if (state_nxt != IDLE) begin
      key_busy_nxt = 1'b1;
    end
    if ((state inside {PRESSED, DB_RELEASE}) && (hold_cnt == LONG_LAST)) begin
      key_long_nxt = 1'b1;
    end
  end

  assign kif.key_out  = key_out_q;
  assign kif.key_long = key_long_q;
  assign kif.key_busy = key_busy_q;

endmodule

// File: tb/tb_key_debounce.sv
module tb_key_debounce;
  import key_pkg::*;

  localparam int DEB  = 4;
  localparam int LONG = 20;
  localparam int LAT  = DEB + 2;

  localparam int EV_FALL = 0;
  localparam int EV_RISE = 1;
  localparam int EV_LONG = 2;

  typedef struct {
    int kind;
    int cyc;
  } ev_t;

  logic clk;
  logic rst_n;
  int   cyc;
  int   n_cmp;
  int   n_bad;
  ev_t  sb[$];
  logic prev_out;

  key_debounce_if kif ();

  key_debounce #(
    .DEB_CYC  (DEB),
    .LONG_CYC (LONG),
    .CNT_W    (26)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .kif   (kif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard monitor: every edge of key_out and every key_long cycle must
  // match the next expected event, both in kind and in cycle number.
  initial prev_out = 1'b1;
  always @(negedge clk) begin
    ev_t e;
    if (!rst_n) begin
      prev_out = kif.key_out;
    end else begin
      if (kif.key_out !== prev_out) begin
        n_cmp++;
        if (sb.size() == 0) begin
          n_bad++;
          $display("FAIL sb_edge: unexpected key_out edge to %b at cycle %0d, none expected", kif.key_out, cyc);
        end else begin
          e = sb.pop_front();
          if (e.kind !== (kif.key_out ? EV_RISE : EV_FALL) || e.cyc !== cyc) begin
            n_bad++;
            $display("FAIL sb_edge: got key_out=%b at cycle %0d, required event kind %0d at cycle %0d",
                     kif.key_out, cyc, e.kind, e.cyc);
          end
        end
      end
      if (kif.key_long === 1'b1) begin
        n_cmp++;
        if (sb.size() == 0) begin
          n_bad++;
          $display("FAIL sb_long: unexpected key_long at cycle %0d, none expected", cyc);
        end else begin
          e = sb.pop_front();
          if (e.kind !== EV_LONG || e.cyc !== cyc) begin
            n_bad++;
            $display("FAIL sb_long: got key_long at cycle %0d, required event kind %0d at cycle %0d",
                     cyc, e.kind, e.cyc);
          end
        end
      end
      prev_out = kif.key_out;
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    kif.key_in = 1'b1;
    rst_n      = 1'b0;
    step(2);
    n_cmp++;
    if (kif.key_out !== 1'b1 || kif.key_long !== 1'b0 || kif.key_busy !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_hold: out/long/busy=%b%b%b, required 100", kif.key_out, kif.key_long, kif.key_busy);
    end
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step(1);
      n_cmp++;
      if (kif.key_out !== 1'b1 || kif.key_long !== 1'b0 || kif.key_busy !== 1'b0) begin
        n_bad++;
        $display("FAIL reset_release: cycle %0d out/long/busy=%b%b%b, required 100",
                 i, kif.key_out, kif.key_long, kif.key_busy);
      end
    end
  endtask

  task automatic test_clean_press();
    int e0;
    int r;
    step(1);
    kif.key_in = 1'b0;
    e0 = cyc;
    sb.push_back('{EV_FALL, e0 + LAT});
    step(2);
    n_cmp++;
    if (kif.key_busy !== 1'b0) begin
      n_bad++;
      $display("FAIL press_busy_early: busy=%b, required 0", kif.key_busy);
    end
    step(1);
    n_cmp++;
    if (kif.key_busy !== 1'b1) begin
      n_bad++;
      $display("FAIL press_busy_rise: busy=%b, required 1", kif.key_busy);
    end
    step(2);
    n_cmp++;
    if (kif.key_out !== 1'b1) begin
      n_bad++;
      $display("FAIL press_out_early: key_out=%b, required 1", kif.key_out);
    end
    step(1);
    n_cmp++;
    if (kif.key_out !== 1'b0) begin
      n_bad++;
      $display("FAIL press_out_fall: key_out=%b, required 0", kif.key_out);
    end
    step(4);
    kif.key_in = 1'b1;
    r = cyc;
    sb.push_back('{EV_RISE, r + LAT});
    step(LAT - 1);
    n_cmp++;
    if (kif.key_out !== 1'b0 || kif.key_busy !== 1'b1) begin
      n_bad++;
      $display("FAIL release_early: out/busy=%b%b, required 01", kif.key_out, kif.key_busy);
    end
    step(1);
    n_cmp++;
    if (kif.key_out !== 1'b1 || kif.key_busy !== 1'b0) begin
      n_bad++;
      $display("FAIL release_done: out/busy=%b%b, required 10", kif.key_out, kif.key_busy);
    end
    step(2);
  endtask

  task automatic test_bounce();
    logic stuck;
    stuck = 1'b0;
    kif.key_in = 1'b0;
    for (int i = 0; i < 3; i++) begin step(1); if (kif.key_out !== 1'b1) stuck = 1'b1; end
    kif.key_in = 1'b1;
    step(1);
    if (kif.key_out !== 1'b1) stuck = 1'b1;
    kif.key_in = 1'b0;
    for (int i = 0; i < 3; i++) begin step(1); if (kif.key_out !== 1'b1) stuck = 1'b1; end
    kif.key_in = 1'b1;
    for (int i = 0; i < 8; i++) begin step(1); if (kif.key_out !== 1'b1) stuck = 1'b1; end
    n_cmp++;
    if (stuck !== 1'b0) begin
      n_bad++;
      $display("FAIL bounce_out: key_out left 1 during bounce, required stay 1");
    end
    n_cmp++;
    if (dut.state !== IDLE || dut.deb_cnt !== 26'd0 || kif.key_busy !== 1'b0) begin
      n_bad++;
      $display("FAIL bounce_idle: state=%0d deb_cnt=%0d busy=%b, required 0 0 0",
               dut.state, dut.deb_cnt, kif.key_busy);
    end
  endtask

  task automatic test_release_bounce();
    int   e0;
    int   r;
    logic rose;
    rose = 1'b0;
    kif.key_in = 1'b0;
    e0 = cyc;
    sb.push_back('{EV_FALL, e0 + LAT});
    sb.push_back('{EV_LONG, e0 + LAT + LONG});
    step(9);
    kif.key_in = 1'b1;
    step(1);
    if (kif.key_out !== 1'b0) rose = 1'b1;
    step(1);
    if (kif.key_out !== 1'b0) rose = 1'b1;
    kif.key_in = 1'b0;
    for (int i = 0; i < 19; i++) begin step(1); if (kif.key_out !== 1'b0) rose = 1'b1; end
    n_cmp++;
    if (rose !== 1'b0) begin
      n_bad++;
      $display("FAIL relbounce_out: key_out rose during release bounce, required stay 0");
    end
    n_cmp++;
    if (dut.state !== PRESSED || dut.hold_cnt !== 26'(LONG)) begin
      n_bad++;
      $display("FAIL relbounce_state: state=%0d hold_cnt=%0d, required %0d %0d",
               dut.state, dut.hold_cnt, PRESSED, LONG);
    end
    kif.key_in = 1'b1;
    r = cyc;
    sb.push_back('{EV_RISE, r + LAT});
    step(LAT + 2);
  endtask

  task automatic test_long_hold();
    int e0;
    int r;
    kif.key_in = 1'b0;
    e0 = cyc;
    sb.push_back('{EV_FALL, e0 + LAT});
    sb.push_back('{EV_LONG, e0 + LAT + LONG});
    step(LAT + LONG - 1);
    n_cmp++;
    if (kif.key_long !== 1'b0) begin
      n_bad++;
      $display("FAIL long_early: key_long=%b, required 0", kif.key_long);
    end
    step(1);
    n_cmp++;
    if (kif.key_long !== 1'b1) begin
      n_bad++;
      $display("FAIL long_fire: key_long=%b, required 1", kif.key_long);
    end
    step(1);
    n_cmp++;
    if (kif.key_long !== 1'b0) begin
      n_bad++;
      $display("FAIL long_width: key_long=%b, required 0", kif.key_long);
    end
    step(60 - LAT - LONG - 1);
    n_cmp++;
    if (dut.hold_cnt !== 26'(LONG) || kif.key_out !== 1'b0) begin
      n_bad++;
      $display("FAIL long_sat: hold_cnt=%0d key_out=%b, required %0d 0", dut.hold_cnt, kif.key_out, LONG);
    end
    kif.key_in = 1'b1;
    r = cyc;
    sb.push_back('{EV_RISE, r + LAT});
    step(LAT + 2);
  endtask

  task automatic test_reset_mid();
    int e0;
    int c;
    int r;
    kif.key_in = 1'b0;
    e0 = cyc;
    sb.push_back('{EV_FALL, e0 + LAT});
    step(LAT + LONG - 1);
    n_cmp++;
    if (dut.hold_cnt !== 26'(LONG - 1) || dut.state !== PRESSED) begin
      n_bad++;
      $display("FAIL rmid_pre: hold_cnt=%0d state=%0d, required %0d %0d", dut.hold_cnt, dut.state, LONG - 1, PRESSED);
    end
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (kif.key_out !== 1'b1 || kif.key_long !== 1'b0 || kif.key_busy !== 1'b0) begin
      n_bad++;
      $display("FAIL rmid_async: out/long/busy=%b%b%b, required 100", kif.key_out, kif.key_long, kif.key_busy);
    end
    step(1);
    n_cmp++;
    if (kif.key_out !== 1'b1 || kif.key_long !== 1'b0) begin
      n_bad++;
      $display("FAIL rmid_held: out/long=%b%b, required 10", kif.key_out, kif.key_long);
    end
    rst_n = 1'b1;
    c = cyc;
    sb.push_back('{EV_FALL, c + LAT});
    step(LAT - 1);
    n_cmp++;
    if (kif.key_out !== 1'b1) begin
      n_bad++;
      $display("FAIL rmid_requal: key_out=%b, required 1", kif.key_out);
    end
    step(1);
    n_cmp++;
    if (kif.key_out !== 1'b0) begin
      n_bad++;
      $display("FAIL rmid_fall: key_out=%b, required 0", kif.key_out);
    end
    step(2);
    kif.key_in = 1'b1;
    r = cyc;
    sb.push_back('{EV_RISE, r + LAT});
    step(LAT + 2);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d, required completion", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    n_cmp = 0;
    n_bad = 0;
    test_reset();
    test_clean_press();
    test_bounce();
    test_release_bounce();
    test_long_hold();
    test_reset_mid();
    step(4);
    n_cmp++;
    if (sb.size() !== 0) begin
      n_bad++;
      $display("FAIL sb_drain: %0d expected events never seen, required 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/key_debounce.md
Name: key_debounce

Overview:
- Front-end conditioning stage for a mechanical push-button.
- Synchronises the raw, bouncy, active-low `key_in` pin to `clk`, then filters it with a stable-time debounce FSM.
- Drives a clean level `key_out` directly into the falling-edge press detector downstream, so one physical press yields exactly one falling edge on `key_out`.
- Also emits a one-cycle `key_long` pulse when a press is held past a long-press threshold.

Parameters:
- DEB_CYC, 1_000_000, consecutive stable `clk` samples needed to accept a level change (20 ms @ 50 MHz); legal range 2..2^24.
- LONG_CYC, 50_000_000, cycles in pressed state before `key_long` fires (1 s @ 50 MHz); must be > DEB_CYC.
- CNT_W, 26, counter width; must satisfy 2^CNT_W > LONG_CYC.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  reset; decided: asynchronous, active-low, clock is `clk`.
- key_in  input  1  raw button pin, asynchronous, active-low (1 = released).
- key_out  output  1  debounced level, active-low; reset 1.
- key_long  output  1  one-cycle pulse, long press detected; reset 0.
- key_busy  output  1  high while FSM is not in IDLE; reset 0.

Behaviour:
- Synchroniser: 2 flops, both reset to 1 (idle level). `key_sync` lags `key_in` by 2 edges.
- Because `key_out` resets to 1, release of reset never creates a spurious falling edge downstream.
- FSM states: IDLE, DB_PRESS, PRESSED, DB_RELEASE; reset state IDLE. `deb_cnt` and `hold_cnt` reset to 0.
- IDLE: `key_out`=1. When `key_sync`=0, go to DB_PRESS with `deb_cnt`=1.
- DB_PRESS:
  - `key_sync`=0: `deb_cnt`++.
  - On the edge taking the DEB_CYC-th consecutive low sample: go to PRESSED, `key_out`<=0, `hold_cnt`<=0.
  - `key_sync`=1 at any point: back to IDLE, `deb_cnt`<=0. Bounce shorter than DEB_CYC is fully rejected.
- PRESSED:
  - `key_out`=0; `hold_cnt` increments each cycle and saturates at LONG_CYC (no wrap).
  - On the edge where `hold_cnt` reaches LONG_CYC, `key_long`=1 for exactly one cycle. At most one `key_long` per press.
  - `key_sync`=1: go to DB_RELEASE with `deb_cnt`=1.
- DB_RELEASE:
  - `key_out` stays 0; `hold_cnt` keeps counting, so `key_long` may fire here.
  - DEB_CYC consecutive high samples: go to IDLE, `key_out`<=1.
  - `key_sync`=0 before that: back to PRESSED, `deb_cnt`<=0, `hold_cnt` preserved.
- Latency: `key_out` changes exactly DEB_CYC+2 rising edges after the first edge that samples the new stable `key_in` level.
- `key_busy` = (state != IDLE), registered together with the state.
- Simultaneous events: a threshold hit and a level reversal in the same cycle resolve in favour of the reversal (counter restart).
- Reset mid-operation: all flops return to reset values immediately (async); no `key_long` pulse may straddle reset.
- All outputs are registered; no combinational path from `key_in` to any output.

Decomposition:
- Package `key_pkg` holds:
  - the state enum (IDLE, DB_PRESS, PRESSED, DB_RELEASE);
  - the idle level constant KEY_IDLE=1'b1;
  - default DEB_CYC and LONG_CYC constants, shared with the downstream press detector and the bench.
- Sub-module `key_sync`: 2-flop synchroniser with a reset-value parameter; reusable for other async pins.

Test Plan (sim params DEB_CYC=4, LONG_CYC=20):
- Reset only, `key_in`=1 held: `key_out`=1, `key_long`=0, `key_busy`=0 through and after reset release; downstream detector sees no edge.
- Clean press: `key_in` 1->0 at edge 0, held low → `key_out` falls at edge 6, `key_busy` rises at edge 3; release → `key_out` rises 6 edges after the release edge.
- Bounce: `key_in` low 3 cycles, high 1, low 3, high → `key_out` stays 1 throughout, FSM returns to IDLE, `deb_cnt`=0.
- Release bounce: while pressed, `key_in` high 2 cycles then low → `key_out` stays 0, `key_long` still fires 20 cycles after `key_out` fell.
- Long hold 60 cycles: exactly one `key_long` pulse 20 cycles after `key_out` falls; no second pulse; `hold_cnt` saturates at 20.
- Async reset asserted in PRESSED at `hold_cnt`=19: `key_out`=1 and `key_long`=0 immediately; with `key_in` still low after reset, the full DEB_CYC+2 qualification is required before `key_out` falls again.
